ppi_nport: RTL and testbench
============================

PPI_NPORT -- requirements
Module: ppi_nport

Interface
REQ-001 Parameter NPORTS, default 3: number of W-bit peripheral ports (1..8).
REQ-002 Parameter W, default 8: port and bus data width (W >= NPORTS).
REQ-003 Parameter FIFO_DEPTH, default 4: strobed-input FIFO entries per port (power of 2, >= 2).
REQ-004 Parameter ADDR_W, default 4: register address width (2*NPORTS+2 <= 2**ADDR_W).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 rd  in  1  single-cycle register read strobe.
REQ-008 wr  in  1  single-cycle register write strobe (rd and wr never both high).
REQ-009 addr  in  ADDR_W  register address.
REQ-010 wdata  in  W  write data.
REQ-011 rdata  out  W  read data, registered.
REQ-012 port_in  in  NPORTS*W  pad input values, port p at [p*W +: W].
REQ-013 port_out  out  NPORTS*W  pad output values.
REQ-014 port_oe  out  NPORTS  per-port output enable.
REQ-015 stb_n  in  NPORTS  asynchronous strobe from device, active-low.
REQ-016 ack_n  in  NPORTS  asynchronous acknowledge from device, active-low.
REQ-017 ibf  out  NPORTS  input buffer full.
REQ-018 obf  out  NPORTS  output buffer full.
REQ-019 irq  out  1  OR of (pending[p] & irq_en[p]).

Function
REQ-020 Register map: addr 2p = DATA[p]; addr 2p+1 = CTRL[p] (bits[1:0] mode, bit[2] irq_en, rest read 0); addr 2*NPORTS = PEND (pending[NPORTS-1:0]); addr 2*NPORTS+1 = ERR (bit p = overflow[p]); other addresses read 0, writes ignored.
REQ-021 Modes: 00 basic input, 01 basic output, 10 strobed input, 11 strobed output.
REQ-022 rdata updates the cycle after rd with addressed value; holds otherwise.
REQ-023 stb_n/ack_n pass a 2-flop synchroniser; falling edge detected on the synchronised signal (3 clk after pad edge worst case).
REQ-024 Basic input: DATA read returns port_in sampled at rd cycle; port_oe=0.
REQ-025 Basic output: DATA write latches wdata to port_out next cycle; port_oe=1; DATA read returns latch.
REQ-026 Strobed input: on detected stb_n fall, port_in of that cycle pushed to FIFO; DATA read pops head; port_oe=0.
REQ-027 Strobed input: ibf = FIFO full; pending = FIFO non-empty (level).
REQ-028 Push when full (no same-cycle pop): data dropped, overflow[p] set (sticky).
REQ-029 Push and pop same cycle when full: both performed, no overflow; when empty: read returns 0, push stored.
REQ-030 Read of empty FIFO returns 0, no state change.
REQ-031 Strobed output: DATA write latches wdata, sets obf next cycle, clears pending; port_oe=1.
REQ-032 Strobed output: detected ack_n fall clears obf and sets pending (sticky); ack while obf=0 ignored.
REQ-033 Write while obf=1: latch overwritten, overflow[p] set, obf stays 1.
REQ-034 Same-cycle DATA write and ack fall: write wins (obf=1, pending=0).
REQ-035 PEND write: 1 clears output-mode pending bits; no effect on input-mode pending. ERR write: 1 clears bit.
REQ-036 CTRL write changing mode: FIFO flushed, obf, pending, overflow for that port cleared, port_out latch kept.
REQ-037 irq combinational from registered pending and irq_en.

Reset
REQ-038 reset clears: CTRL to 0 (basic input, irq disabled), port_out 0, port_oe 0, FIFOs empty, ibf 0, obf 0, pending 0, ERR 0, rdata 0, synchronisers to 1.
REQ-039 reset mid-transfer aborts immediately; no push or ack recorded for edges during reset.

Structure
REQ-040 Package ppi_pkg holds mode encodings and register offset functions.
REQ-041 Sub-module ppi_port_fifo (W, FIFO_DEPTH; push, pop, full, empty, flush) instantiated once per port by generate.

Verification
REQ-042 Reset, read CTRL[0] -> 0x00; port_oe=0, irq=0.
REQ-043 CTRL[1]=0x01, write DATA[1]=0xA5 -> port_out[15:8]=0xA5, port_oe[1]=1.
REQ-044 CTRL[0]=0x06, 4 strobes with port_in 0x11..0x44 -> ibf[0]=1, irq=1; 5th strobe 0x55 -> ERR=0x01; 4 reads return 0x11,0x22,0x33,0x44, ibf=0, irq=0.
REQ-045 CTRL[2]=0x07, write DATA[2]=0x3C -> obf[2]=1; ack_n pulse -> obf[2]=0, PEND=0x04, irq=1; write PEND=0x04 -> irq=0.
REQ-046 Full FIFO, rd of DATA same cycle as detected strobe -> no overflow, FIFO stays full, new value last out.
REQ-047 Assert reset with obf=1 and FIFO non-empty -> all outputs to reset values within same cycle.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared mode encodings and register-map helpers for the parallel peripheral interface.
package ppi_pkg;

  // Per-port operating modes, held in CTRL[p] bits [1:0].
  localparam logic [1:0] MODE_BASIC_IN  = 2'b00;
  localparam logic [1:0] MODE_BASIC_OUT = 2'b01;
  localparam logic [1:0] MODE_STB_IN    = 2'b10;
  localparam logic [1:0] MODE_STB_OUT   = 2'b11;

  // Register offsets: DATA/CTRL pairs per port, then PEND and ERR.
  function automatic int data_addr(input int p);
    return 2 * p;
  endfunction

  function automatic int ctrl_addr(input int p);
    return 2 * p + 1;
  endfunction

  function automatic int pend_addr(input int nports);
    return 2 * nports;
  endfunction

  function automatic int err_addr(input int nports);
    return 2 * nports + 1;
  endfunction

  // Both output modes have bit 0 set, so it doubles as the pad output enable.
  function automatic logic mode_drives(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/ppi_port_fifo.sv
// Small synchronous FIFO that buffers strobed-input samples for one port.
// A pop is honoured only when non-empty. A push is honoured when not full,
// or when a pop happens in the same cycle. A flush empties the FIFO and
// overrides any same-cycle push or pop.
module ppi_port_fifo
  import ppi_pkg::*;
#(
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ppi_nport.sv
// Multi-port parallel peripheral interface with a small register bus.
// Bus protocol: rd and wr are single-cycle strobes that are never both high.
// A write takes effect on the clock edge that ends its cycle. A read
// presents the addressed value on rdata from the next cycle onward, and
// rdata holds that value until the next rd.
module ppi_nport
  import ppi_pkg::*;
#(
  parameter int NPORTS     = 3,
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        rdata,
  input  logic [NPORTS*W-1:0] port_in,
  output logic [NPORTS*W-1:0] port_out,
  output logic [NPORTS-1:0]   port_oe,
  input  logic [NPORTS-1:0]   stb_n,
  input  logic [NPORTS-1:0]   ack_n,
  output logic [NPORTS-1:0]   ibf,
  output logic [NPORTS-1:0]   obf,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(pend_addr(NPORTS));
  localparam logic [ADDR_W-1:0] A_ERR  = ADDR_W'(err_addr(NPORTS));

  logic [NPORTS-1:0]   pending;
  logic [NPORTS-1:0]   ien_vec;
  logic [NPORTS-1:0]   ovf_vec;
  logic [NPORTS*W-1:0] data_rd;
  logic [NPORTS*W-1:0] ctrl_rd;
  logic [W-1:0]        rd_val;
  logic                pend_wr;
  logic                err_wr;

  assign pend_wr = wr & (addr == A_PEND);
  assign err_wr  = wr & (addr == A_ERR);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(data_addr(p));
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ctrl_addr(p));

    logic [2:0]   stb_sh;
    logic [2:0]   ack_sh;
    logic [1:0]   mode;
    logic         irq_en;
    logic [W-1:0] latch;
    logic         obf_r;
    logic         pend_r;
    logic         ovf_r;
    logic         data_wr;
    logic         ctrl_wr;
    logic         data_rd_sel;
    logic         mode_chg;
    logic         stb_fall;
    logic         ack_fall;
    logic         out_wr;
    logic         f_push;
    logic         f_pop;
    logic         f_full;
    logic         f_empty;
    logic [W-1:0] f_dout;
    logic         ovf_in;

    assign data_wr     = wr & (addr == A_DATA);
    assign ctrl_wr     = wr & (addr == A_CTRL);
    assign data_rd_sel = rd & (addr == A_DATA);
    assign mode_chg    = ctrl_wr & (wdata[1:0] != mode);

    // sh[0], sh[1] form the synchroniser; sh[2] is the previous synchronised value.
    assign stb_fall = stb_sh[2] & ~stb_sh[1];
    assign ack_fall = ack_sh[2] & ~ack_sh[1] & (mode == MODE_STB_OUT) & obf_r;

    assign out_wr = data_wr & (mode == MODE_STB_OUT);
    assign f_push = stb_fall & (mode == MODE_STB_IN);
    assign f_pop  = data_rd_sel & (mode == MODE_STB_IN);
    // A pop only happens when full is also non-empty, so the pop term alone suffices.
    assign ovf_in = f_push & f_full & ~f_pop;

    ppi_port_fifo #(
      .W          (W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (mode_chg),
      .push  (f_push),
      .pop   (f_pop),
      .din   (port_in[p*W +: W]),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty)
    );

    // Synchronisers, control register, output latch and handshake flags.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stb_sh <= '1;
        ack_sh <= '1;
        mode   <= MODE_BASIC_IN;
        irq_en <= 1'b0;
        latch  <= '0;
        obf_r  <= 1'b0;
        pend_r <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        stb_sh <= {stb_sh[1:0], stb_n[p]};
        ack_sh <= {ack_sh[1:0], ack_n[p]};
        if (ctrl_wr) begin
          mode   <= wdata[1:0];
          irq_en <= wdata[2];
        end
        if (mode_chg) begin
          obf_r  <= 1'b0;
          pend_r <= 1'b0;
          ovf_r  <= 1'b0;
        end else begin
          // Later assignments win: PEND clear < ack < data write.
          if (pend_wr && wdata[p]) pend_r <= 1'b0;
          if (ack_fall) begin
            obf_r  <= 1'b0;
            pend_r <= 1'b1;
          end
          if (out_wr) begin
            latch  <= wdata;
            obf_r  <= 1'b1;
            pend_r <= 1'b0;
          end
          if (data_wr && (mode == MODE_BASIC_OUT)) latch <= wdata;
          // An ack in the same cycle consumed the old data, so that is not an overrun.
          if (err_wr && wdata[p]) ovf_r <= 1'b0;
          if (ovf_in || (out_wr && obf_r && !ack_fall)) ovf_r <= 1'b1;
        end
      end
    end

    assign port_out[p*W +: W] = latch;
    assign port_oe[p]         = mode_drives(mode);
    assign ibf[p]             = (mode == MODE_STB_IN) & f_full;
    assign obf[p]             = obf_r;
    assign ien_vec[p]         = irq_en;
    assign ovf_vec[p]         = ovf_r;
    assign pending[p]         = (mode == MODE_STB_IN)  ? ~f_empty :
                                (mode == MODE_STB_OUT) ? pend_r   : 1'b0;
    assign ctrl_rd[p*W +: W]  = W'({irq_en, mode});
    assign data_rd[p*W +: W]  = (mode == MODE_BASIC_IN) ? port_in[p*W +: W] :
                                (mode == MODE_STB_IN)   ? (f_empty ? '0 : f_dout) :
                                latch;
  end

  // Read-data mux; unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    if (addr == A_PEND) rd_val = W'(pending);
    if (addr == A_ERR)  rd_val = W'(ovf_vec);
    for (int p = 0; p < NPORTS; p++) begin
      if (addr == ADDR_W'(data_addr(p))) rd_val = data_rd[p*W +: W];
      if (addr == ADDR_W'(ctrl_addr(p))) rd_val = ctrl_rd[p*W +: W];
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (rd) rdata <= rd_val;
  end

  assign irq = |(pending & ien_vec);

endmodule

// File: tb/tb_ppi_nport.sv
// Directed plus randomized bench for ppi_nport against a transaction-level model.
module tb_ppi_nport;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            rd, wr;
  logic [AW-1:0]   addr;
  logic [W-1:0]    wdata;
  logic [W-1:0]    rdata;
  logic [NP*W-1:0] port_in;
  logic [NP*W-1:0] port_out;
  logic [NP-1:0]   port_oe;
  logic [NP-1:0]   stb_n, ack_n;
  logic [NP-1:0]   ibf, obf;
  logic            irq;

  always #5 clk = ~clk;

  ppi_nport #(.NPORTS(NP), .W(W), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
    .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf), .obf(obf), .irq(irq)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]   m_mode  [NP];
  logic         m_ien   [NP];
  logic [W-1:0] m_latch [NP];
  logic         m_obf   [NP];
  logic         m_pend  [NP];
  logic         m_ovf   [NP];
  logic [W-1:0] m_fifo  [NP][D];
  int           m_cnt   [NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_mode[p] = 2'b00; m_ien[p] = 1'b0; m_latch[p] = '0;
      m_obf[p] = 1'b0; m_pend[p] = 1'b0; m_ovf[p] = 1'b0; m_cnt[p] = 0;
    end
  endtask

  function automatic logic [NP-1:0] m_pending();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      if (m_mode[p] == 2'b10) v[p] = (m_cnt[p] != 0);
      else if (m_mode[p] == 2'b11) v[p] = m_pend[p];
    end
    return v;
  endfunction

  task automatic model_write(input int a, input logic [W-1:0] d);
    if (a < 2 * NP) begin
      int p;
      p = a / 2;
      if (a % 2 == 0) begin
        if (m_mode[p] == 2'b01) m_latch[p] = d;
        else if (m_mode[p] == 2'b11) begin
          if (m_obf[p]) m_ovf[p] = 1'b1;
          m_latch[p] = d; m_obf[p] = 1'b1; m_pend[p] = 1'b0;
        end
      end else begin
        if (d[1:0] != m_mode[p]) begin
          m_cnt[p] = 0; m_obf[p] = 1'b0; m_pend[p] = 1'b0; m_ovf[p] = 1'b0;
        end
        m_mode[p] = d[1:0];
        m_ien[p]  = d[2];
      end
    end else if (a == 2 * NP) begin
      for (int p = 0; p < NP; p++) if (d[p]) m_pend[p] = 1'b0;
    end else if (a == 2 * NP + 1) begin
      for (int p = 0; p < NP; p++) if (d[p]) m_ovf[p] = 1'b0;
    end
  endtask

  task automatic model_read(input int a, output logic [W-1:0] v);
    v = '0;
    if (a < 2 * NP) begin
      int p;
      p = a / 2;
      if (a % 2 == 1) v = {5'b0, m_ien[p], m_mode[p]};
      else case (m_mode[p])
        2'b00: v = port_in[p*W +: W];
        2'b10: if (m_cnt[p] > 0) begin
                 v = m_fifo[p][0];
                 for (int i = 0; i < D - 1; i++) m_fifo[p][i] = m_fifo[p][i+1];
                 m_cnt[p]--;
               end
        default: v = m_latch[p];
      endcase
    end else if (a == 2 * NP) begin
      v = W'(m_pending());
    end else if (a == 2 * NP + 1) begin
      for (int p = 0; p < NP; p++) v[p] = m_ovf[p];
    end
  endtask

  task automatic model_strobe(input int p, input logic [W-1:0] v);
    if (m_mode[p] == 2'b10) begin
      if (m_cnt[p] == D) m_ovf[p] = 1'b1;
      else begin m_fifo[p][m_cnt[p]] = v; m_cnt[p]++; end
    end
  endtask

  task automatic model_ack(input int p);
    if (m_mode[p] == 2'b11 && m_obf[p]) begin
      m_obf[p] = 1'b0; m_pend[p] = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NP*W-1:0] e_out;
    logic [NP-1:0]   e_oe, e_ibf, e_obf, e_ien;
    for (int p = 0; p < NP; p++) begin
      e_out[p*W +: W] = m_latch[p];
      e_oe[p]  = m_mode[p][0];
      e_ibf[p] = (m_mode[p] == 2'b10) && (m_cnt[p] == D);
      e_obf[p] = m_obf[p];
      e_ien[p] = m_ien[p];
    end
    chk({tag, ".port_out"}, port_out, e_out);
    chk({tag, ".port_oe"},  port_oe,  e_oe);
    chk({tag, ".ibf"},      ibf,      e_ibf);
    chk({tag, ".obf"},      obf,      e_obf);
    chk({tag, ".irq"},      irq,      |(m_pending() & e_ien));
  endtask

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic do_write(input int a, input logic [W-1:0] d);
    wr = 1'b1; addr = AW'(a); wdata = d;
    @(negedge clk);
    wr = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_read(input int a, input string tag);
    logic [W-1:0] e;
    model_read(a, e);
    rd = 1'b1; addr = AW'(a);
    @(negedge clk);
    rd = 1'b0;
    chk(tag, rdata, e);
  endtask

  task automatic do_strobe(input int p, input logic [W-1:0] v);
    port_in[p*W +: W] = v;
    stb_n[p] = 1'b0;
    repeat (4) @(negedge clk);
    model_strobe(p, v);
    stb_n[p] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ack(input int p);
    ack_n[p] = 1'b0;
    repeat (4) @(negedge clk);
    model_ack(p);
    ack_n[p] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Strobe fall is detected in the third cycle after the pad edge; the read lands there.
  task automatic strobe_with_read(input int p, input logic [W-1:0] v, input int a, input string tag);
    logic [W-1:0] e;
    port_in[p*W +: W] = v;
    stb_n[p] = 1'b0;
    repeat (2) @(negedge clk);
    model_read(a, e);
    model_strobe(p, v);
    rd = 1'b1; addr = AW'(a);
    @(negedge clk);
    rd = 1'b0;
    chk(tag, rdata, e);
    stb_n[p] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack_with_write(input int p, input logic [W-1:0] d);
    ack_n[p] = 1'b0;
    repeat (2) @(negedge clk);
    model_ack(p);
    model_write(2 * p, d);
    wr = 1'b1; addr = AW'(2 * p); wdata = d;
    @(negedge clk);
    wr = 1'b0;
    ack_n[p] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    port_in = '0; stb_n = '1; ack_n = '1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst.rdata", rdata, 0);
    chk("rst.port_oe", port_oe, 0);
    chk("rst.irq", irq, 0);
    do_read(1, "rst.ctrl0");
    check_outputs("rst");

    // Basic output on port 1.
    do_write(3, 8'h01);
    do_write(2, 8'hA5);
    chk("bout.port_out1", port_out[15:8], 8'hA5);
    chk("bout.oe1", port_oe[1], 1);
    do_read(2, "bout.readback");
    check_outputs("bout");

    // Strobed input on port 0 with irq enabled, including overflow.
    do_write(1, 8'h06);
    for (int i = 1; i <= 4; i++) begin
      do_strobe(0, W'(8'h11 * i));
      exp_q.push_back(W'(8'h11 * i));
    end
    chk("sin.ibf0", ibf[0], 1);
    chk("sin.irq", irq, 1);
    do_strobe(0, 8'h55);
    do_read(7, "sin.err");
    chk("sin.err_const", rdata, 8'h01);
    for (int i = 0; i < 4; i++) begin
      do_read(0, "sin.pop");
      chk("sin.order", rdata, exp_q.pop_front());
    end
    chk("sin.ibf0_empty", ibf[0], 0);
    chk("sin.irq_empty", irq, 0);
    do_read(0, "sin.empty_read");
    do_write(7, 8'h01);
    do_read(7, "sin.err_cleared");
    check_outputs("sin");

    // Strobed output on port 2.
    do_write(5, 8'h07);
    do_write(4, 8'h3C);
    chk("sout.obf2", obf[2], 1);
    do_ack(2);
    chk("sout.obf2_acked", obf[2], 0);
    do_read(6, "sout.pend");
    chk("sout.pend_const", rdata, 8'h04);
    chk("sout.irq", irq, 1);
    do_write(6, 8'h04);
    chk("sout.irq_cleared", irq, 0);
    do_write(4, 8'h5A);
    do_write(4, 8'h5B);
    do_read(7, "sout.overrun_err");
    do_write(7, 8'h04);
    ack_with_write(2, 8'h6C);
    chk("sout.ack_write_obf", obf[2], 1);
    do_read(6, "sout.ack_write_pend");
    do_read(7, "sout.ack_write_err");
    check_outputs("sout");

    // Full FIFO with read coinciding with a detected strobe.
    for (int i = 1; i <= 4; i++) do_strobe(0, W'(8'h60 + i));
    strobe_with_read(0, 8'h65, 0, "full.same_cycle");
    chk("full.ibf0", ibf[0], 1);
    do_read(7, "full.no_overflow");
    for (int i = 0; i < 4; i++) do_read(0, "full.drain");
    check_outputs("full");

    // Randomized operations.
    for (int it = 0; it < 250; it++) begin
      int op, p;
      op = $urandom_range(0, 9);
      p  = $urandom_range(0, NP - 1);
      case (op)
        0: do_write(2 * p + 1, W'($urandom_range(0, 7)));
        1: do_write(2 * p, W'($urandom_range(0, 255)));
        2, 3: begin
          port_in = NP*W'($urandom);
          do_read(2 * p, "rnd.data_read");
        end
        4: do_strobe(p, W'($urandom_range(0, 255)));
        5: do_ack(p);
        6: do_read(2 * NP + $urandom_range(0, 1), "rnd.status_read");
        7: do_write(2 * NP + $urandom_range(0, 1), W'($urandom_range(0, 255)));
        8: begin
          do_write($urandom_range(2 * NP + 2, 15), W'($urandom_range(0, 255)));
          do_read($urandom_range(2 * NP + 2, 15), "rnd.unmapped");
        end
        default: strobe_with_read(p, W'($urandom_range(0, 255)), 2 * p, "rnd.strobe_read");
      endcase
      check_outputs("rnd");
    end

    // Asynchronous reset with obf set and a non-empty FIFO.
    do_write(1, 8'h06);
    do_strobe(0, 8'h77);
    do_strobe(0, 8'h78);
    do_write(5, 8'h07);
    do_write(4, 8'h99);
    do_read(4, "arst.pre_read");
    chk("arst.pre_obf2", obf[2], 1);
    #2 reset = 1'b1;
    #1;
    chk("arst.port_out", port_out, 0);
    chk("arst.port_oe", port_oe, 0);
    chk("arst.ibf", ibf, 0);
    chk("arst.obf", obf, 0);
    chk("arst.irq", irq, 0);
    chk("arst.rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("arst.after");
    do_read(1, "arst.ctrl0");
    do_read(7, "arst.err");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
